// File: rtl/mysoc_pio_pkg.sv
// Shared definitions for the MySoc PIO slave: register addresses, edge
// encodings and the read-path zero-extension helper.
package mysoc_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Clears every bit at or above 'width' so readdata never leaks stale upper bits.
  function automatic logic [31:0] zext32(input logic [31:0] v, input int width);
    logic [31:0] m;
    m = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    return v & m;
  endfunction

endpackage

// File: rtl/mysoc_pio_sync_edge.sv
// Input conditioning for the PIO: two-flop synchroniser, previous-value
// register and a prime counter that suppresses edges straight out of reset.
module mysoc_pio_sync_edge
  import mysoc_pio_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_pins,
  output logic [WIDTH-1:0] o_syncIn,
  output logic [WIDTH-1:0] o_edgeDet
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_prev;
  logic [1:0]       r_primeCnt;
  logic [WIDTH-1:0] w_edgeRaw;
  logic             w_primed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_prev     <= '0;
      r_primeCnt <= 2'd0;
    end else begin
      r_s1   <= i_pins;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (r_primeCnt != 2'd3)
        r_primeCnt <= r_primeCnt + 2'd1;
    end
  end

  always_comb begin
    w_edgeRaw = '0;
    case (EDGE_TYPE)
      EDGE_FALL: w_edgeRaw = ~r_s2 & r_prev;
      EDGE_ANY:  w_edgeRaw = r_s2 ^ r_prev;
      default:   w_edgeRaw = r_s2 & ~r_prev;
    endcase
  end

  // Pins already high at reset release would otherwise look like a rising edge.
  assign w_primed  = (r_primeCnt == 2'd3);
  assign o_edgeDet = w_edgeRaw & {WIDTH{w_primed}};
  assign o_syncIn  = r_s2;

endmodule

// File: rtl/mysoc_pio_gen.sv
// Parametrised bidirectional PIO Avalon-MM slave with per-bit direction,
// atomic set/clear, edge capture and a maskable interrupt.
module mysoc_pio_gen
  import mysoc_pio_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic [WIDTH-1:0] r_dataOut;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_capture;

  logic             w_write;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_syncIn;
  logic [WIDTH-1:0] w_edgeDet;
  logic [WIDTH-1:0] w_readVal;
  logic             w_unusedWd;

  assign w_write = chipselect & ~write_n;
  assign w_wd    = writedata[WIDTH-1:0];
  // Upper writedata bits are architecturally ignored for narrow ports.
  assign w_unusedWd = ^writedata;

  mysoc_pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_syncEdge (
    .clk       (clk),
    .reset     (reset),
    .i_pins    (in_port),
    .o_syncIn  (w_syncIn),
    .o_edgeDet (w_edgeDet)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dataOut <= RESET_VALUE;
      r_dir     <= DIR_RESET;
      r_mask    <= '0;
    end else if (w_write) begin
      case (address)
        ADDR_DATA:   r_dataOut <= w_wd;
        ADDR_DIR:    r_dir     <= w_wd;
        ADDR_MASK:   r_mask    <= w_wd;
        ADDR_OUTSET: r_dataOut <= r_dataOut | w_wd;
        ADDR_OUTCLR: r_dataOut <= r_dataOut & ~w_wd;
        default:     ;
      endcase
    end
  end

  // A new edge in the same cycle as a write-1-to-clear wins, so no event is lost.
  assign w_clr = (w_write && (address == ADDR_EDGE)) ? w_wd : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_capture <= '0;
    else
      r_capture <= (r_capture & ~w_clr) | w_edgeDet;
  end

  always_comb begin
    w_readVal = '0;
    case (address)
      ADDR_DATA: w_readVal = (w_syncIn & ~r_dir) | (r_dataOut & r_dir);
      ADDR_DIR:  w_readVal = r_dir;
      ADDR_MASK: w_readVal = r_mask;
      ADDR_EDGE: w_readVal = r_capture;
      default:   w_readVal = '0;
    endcase
  end

  assign readdata = zext32(32'(w_readVal), WIDTH);
  assign out_port = r_dataOut;
  assign oe_port  = r_dir;
  assign irq      = |(r_capture & r_mask);

endmodule

// File: tb/tb_mysoc_pio_gen.sv
// Scoreboard bench for mysoc_pio_gen: a 6-bit rising-edge instance and a
// 32-bit any-edge instance share clock and reset.
module tb_mysoc_pio_gen;
  import mysoc_pio_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] obsQ[$];
  int          checks = 0;
  int          errors = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [2:0]  addr6 = '0;
  logic        cs6 = 1'b0;
  logic        wn6 = 1'b1;
  logic [31:0] wdata6 = '0;
  logic [31:0] rdata6;
  logic [5:0]  in6 = '0;
  logic [5:0]  out6;
  logic [5:0]  oe6;
  logic        irq6;

  logic [2:0]  addr32 = '0;
  logic        cs32 = 1'b0;
  logic        wn32 = 1'b1;
  logic [31:0] wdata32 = '0;
  logic [31:0] rdata32;
  logic [31:0] in32 = '0;
  logic [31:0] out32;
  logic [31:0] oe32;
  logic        irq32;

  always #5 clk = ~clk;

  mysoc_pio_gen #(
    .WIDTH       (6),
    .RESET_VALUE (6'h15),
    .DIR_RESET   (6'h3F),
    .EDGE_TYPE   (EDGE_RISE)
  ) dut6 (
    .clk        (clk),
    .reset      (reset),
    .address    (addr6),
    .chipselect (cs6),
    .write_n    (wn6),
    .writedata  (wdata6),
    .readdata   (rdata6),
    .in_port    (in6),
    .out_port   (out6),
    .oe_port    (oe6),
    .irq        (irq6)
  );

  mysoc_pio_gen #(
    .WIDTH       (32),
    .RESET_VALUE (32'h0),
    .DIR_RESET   (32'hFFFF_FFFF),
    .EDGE_TYPE   (EDGE_ANY)
  ) dut32 (
    .clk        (clk),
    .reset      (reset),
    .address    (addr32),
    .chipselect (cs32),
    .write_n    (wn32),
    .writedata  (wdata32),
    .readdata   (rdata32),
    .in_port    (in32),
    .out_port   (out32),
    .oe_port    (oe32),
    .irq        (irq32)
  );

  function automatic void expectVal(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    expQ.push_back(e);
  endfunction

  function automatic void sample(input logic [31:0] v);
    obsQ.push_back(v);
  endfunction

  task automatic wr6(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr6 = a; wdata6 = d; cs6 = 1'b1; wn6 = 1'b0;
    @(negedge clk);
    cs6 = 1'b0; wn6 = 1'b1;
  endtask

  task automatic rd6(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr6 = a;
    #1 d = rdata6;
  endtask

  task automatic wr32(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr32 = a; wdata32 = d; cs32 = 1'b1; wn32 = 1'b0;
    @(negedge clk);
    cs32 = 1'b0; wn32 = 1'b1;
  endtask

  task automatic rd32(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr32 = a;
    #1 d = rdata32;
  endtask

  task automatic test_reset();
    logic [31:0] v, o;
    exp_t e;
    expectVal("rst_out", 32'h15);
    expectVal("rst_oe", 32'h3F);
    expectVal("rst_irq", 32'h0);
    expectVal("rst_dir_rd", 32'h3F);
    expectVal("rst_mask_rd", 32'h0);
    expectVal("rst32_oe", 32'hFFFF_FFFF);
    expectVal("rst32_out", 32'h0);
    @(negedge clk);
    sample(32'(out6)); sample(32'(oe6)); sample(32'(irq6));
    rd6(ADDR_DIR, v);  sample(v);
    rd6(ADDR_MASK, v); sample(v);
    sample(oe32); sample(out32);
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: got no sample, expected %h", e.name, e.val);
      end else begin
        o = obsQ.pop_front();
        if (o !== e.val) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_out_set_clr();
    logic [31:0] v, o;
    exp_t e;
    expectVal("data_wr", 32'h0F);
    expectVal("outset", 32'h3F);
    expectVal("outclr", 32'h3E);
    expectVal("rd_outset", 32'h0);
    expectVal("rd_outclr", 32'h0);
    expectVal("rd_data_out", 32'h3E);
    expectVal("wr67_ignored", 32'h3E);
    expectVal("wr67_dir_kept", 32'h3F);
    expectVal("rd_addr6", 32'h0);
    wr6(ADDR_DATA, 32'h0F);   sample(32'(out6));
    wr6(ADDR_OUTSET, 32'h30); sample(32'(out6));
    wr6(ADDR_OUTCLR, 32'h01); sample(32'(out6));
    rd6(ADDR_OUTSET, v); sample(v);
    rd6(ADDR_OUTCLR, v); sample(v);
    rd6(ADDR_DATA, v);   sample(v);
    wr6(3'd6, 32'hFFFF_FFFF);
    wr6(3'd7, 32'hFFFF_FFFF);
    sample(32'(out6));
    rd6(ADDR_DIR, v); sample(v);
    rd6(3'd6, v);     sample(v);
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: got no sample, expected %h", e.name, e.val);
      end else begin
        o = obsQ.pop_front();
        if (o !== e.val) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_input_path();
    logic [31:0] o;
    exp_t e;
    expectVal("dir_oe", 32'h0F);
    expectVal("data_after_k", 32'h0E);
    expectVal("data_after_k1", 32'h2E);
    expectVal("cap_after_k1", 32'h0);
    expectVal("cap_after_k2", 32'h20);
    expectVal("irq_unmasked", 32'h0);
    wr6(ADDR_DIR, 32'h0F); sample(32'(oe6));
    @(negedge clk);
    addr6 = ADDR_DATA; in6 = 6'h20;
    @(negedge clk); #1 sample(rdata6);
    @(negedge clk); #1 sample(rdata6);
    addr6 = ADDR_EDGE; #1 sample(rdata6);
    @(negedge clk); #1 sample(rdata6);
    sample(32'(irq6));
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: got no sample, expected %h", e.name, e.val);
      end else begin
        o = obsQ.pop_front();
        if (o !== e.val) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] v, o;
    exp_t e;
    expectVal("irq_mask0", 32'h0);
    expectVal("irq_masked_on", 32'h1);
    expectVal("irq_after_w1c", 32'h0);
    expectVal("cap_after_w1c", 32'h0);
    expectVal("fall_ignored", 32'h0);
    expectVal("edge_beats_clr", 32'h20);
    expectVal("irq_edge_beats_clr", 32'h1);
    expectVal("w0_keeps_cap", 32'h20);
    expectVal("cap_final_clr", 32'h0);
    expectVal("irq_final", 32'h0);
    sample(32'(irq6));
    wr6(ADDR_MASK, 32'h20); sample(32'(irq6));
    wr6(ADDR_EDGE, 32'h20); sample(32'(irq6));
    rd6(ADDR_EDGE, v); sample(v);
    @(negedge clk); in6 = 6'h00;
    repeat (4) @(negedge clk);
    rd6(ADDR_EDGE, v); sample(v);
    @(negedge clk); in6 = 6'h20;
    @(negedge clk);
    @(negedge clk);
    addr6 = ADDR_EDGE; wdata6 = 32'h20; cs6 = 1'b1; wn6 = 1'b0;
    @(negedge clk);
    cs6 = 1'b0; wn6 = 1'b1;
    #1 sample(rdata6);
    sample(32'(irq6));
    wr6(ADDR_EDGE, 32'h00);
    rd6(ADDR_EDGE, v); sample(v);
    wr6(ADDR_EDGE, 32'h20);
    rd6(ADDR_EDGE, v); sample(v);
    sample(32'(irq6));
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: got no sample, expected %h", e.name, e.val);
      end else begin
        o = obsQ.pop_front();
        if (o !== e.val) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_reset_prime();
    logic [31:0] v, o;
    exp_t e;
    expectVal("irq_pending", 32'h1);
    expectVal("irq_async_drop", 32'h0);
    expectVal("out_async_rst", 32'h15);
    expectVal("oe_async_rst", 32'h3F);
    expectVal("prime_no_cap", 32'h0);
    expectVal("prime_irq", 32'h0);
    expectVal("rst_mask_back", 32'h0);
    expectVal("rst_dir_back", 32'h3F);
    expectVal("rst_data_back", 32'h15);
    expectVal("cap_after_prime", 32'h3F);
    @(negedge clk); in6 = 6'h3F;
    repeat (4) @(negedge clk);
    wr6(ADDR_MASK, 32'h3F); sample(32'(irq6));
    @(negedge clk);
    addr6 = ADDR_DATA; wdata6 = 32'h0; cs6 = 1'b1; wn6 = 1'b0;
    #2 reset = 1'b1;
    #1 sample(32'(irq6)); sample(32'(out6)); sample(32'(oe6));
    @(negedge clk); cs6 = 1'b0; wn6 = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (6) @(negedge clk);
    rd6(ADDR_EDGE, v); sample(v);
    sample(32'(irq6));
    rd6(ADDR_MASK, v); sample(v);
    rd6(ADDR_DIR, v);  sample(v);
    rd6(ADDR_DATA, v); sample(v);
    @(negedge clk); in6 = 6'h00;
    repeat (4) @(negedge clk);
    in6 = 6'h3F;
    repeat (4) @(negedge clk);
    rd6(ADDR_EDGE, v); sample(v);
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: got no sample, expected %h", e.name, e.val);
      end else begin
        o = obsQ.pop_front();
        if (o !== e.val) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_edge32();
    logic [31:0] v, o;
    exp_t e;
    expectVal("w32_dir", 32'hFFFF_FFFF);
    expectVal("w32_rise_cap", 32'h8000_0000);
    expectVal("w32_clr1", 32'h0);
    expectVal("w32_fall_cap", 32'h8000_0000);
    expectVal("w32_clr2", 32'h0);
    expectVal("w32_addr7", 32'h0);
    expectVal("w32_irq", 32'h0);
    expectVal("w32_data_rd", 32'hA5A5_0000);
    expectVal("w32_out", 32'hA5A5_0000);
    rd32(ADDR_DIR, v); sample(v);
    @(negedge clk); in32[31] = 1'b1;
    repeat (3) @(negedge clk);
    rd32(ADDR_EDGE, v); sample(v);
    wr32(ADDR_EDGE, 32'h8000_0000);
    rd32(ADDR_EDGE, v); sample(v);
    @(negedge clk); in32[31] = 1'b0;
    repeat (3) @(negedge clk);
    rd32(ADDR_EDGE, v); sample(v);
    wr32(ADDR_EDGE, 32'h8000_0000);
    rd32(ADDR_EDGE, v); sample(v);
    rd32(3'd7, v); sample(v);
    sample(32'(irq32));
    wr32(ADDR_DATA, 32'hA5A5_0000);
    rd32(ADDR_DATA, v); sample(v);
    sample(out32);
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: got no sample, expected %h", e.name, e.val);
      end else begin
        o = obsQ.pop_front();
        if (o !== e.val) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, o, e.val);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_out_set_clr();
    test_input_path();
    test_irq();
    test_reset_prime();
    test_edge32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
